// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file (2 read ports, 1 write port)
// with a per-register busy scoreboard for RAW hazard detection at decode.
// R0 is hardwired to zero and is never busy. Addresses at or above NUM_REGS
// read as zero and non-busy, and writes or issues to them are dropped.
// Optional feature: define RF_BYPASS_EN to forward same-cycle writeback data
// to the read ports and drop the retiring busy bit in that same cycle.
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  input  logic              use1,
  input  logic              use2
);

  localparam int DEPTH = 1 << ADDR_W;

  // One bit per encodable address: 1 when that address maps to a real register.
  function automatic logic [DEPTH-1:0] build_mask();
    logic [DEPTH-1:0] m;
    m = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i < NUM_REGS) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0] VALID_MASK = build_mask();

  // True for a real, non-R0 register: the only addresses that hold state.
  function automatic logic reg_ok(input logic [ADDR_W-1:0] a);
    return VALID_MASK[a] && (a != ADDR_W'(0));
  endfunction

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic [DATA_W-1:0]   raw_data1_s;
  logic [DATA_W-1:0]   raw_data2_s;
  logic                raw_busy1_s;
  logic                raw_busy2_s;
  logic                fwd1_s;
  logic                fwd2_s;

  // Scoreboard next state: issue sets, writeback clears, set wins on a tie.
  always_comb begin
    busy_next_s    = busy_r;
    busy_next_s[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (issue_en && (issue_addr == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Register storage; writes to R0 or unmapped addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en && reg_ok(wr_addr)) begin
      regs_r[wr_addr] <= wr_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Stored data and busy bits seen by each read port (zero for R0/unmapped).
  always_comb begin
    raw_data1_s = {DATA_W{1'b0}};
    raw_data2_s = {DATA_W{1'b0}};
    raw_busy1_s = 1'b0;
    raw_busy2_s = 1'b0;
    if (reg_ok(rd_addr1)) begin
      raw_data1_s = regs_r[rd_addr1];
      raw_busy1_s = busy_r[rd_addr1];
    end else begin
      raw_data1_s = {DATA_W{1'b0}};
      raw_busy1_s = 1'b0;
    end
    if (reg_ok(rd_addr2)) begin
      raw_data2_s = regs_r[rd_addr2];
      raw_busy2_s = busy_r[rd_addr2];
    end else begin
      raw_data2_s = {DATA_W{1'b0}};
      raw_busy2_s = 1'b0;
    end
  end

  // Forwarding hits: a live writeback to the register a port is reading.
  always_comb begin
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
`ifdef RF_BYPASS_EN
    fwd1_s = !rst && wr_en && reg_ok(wr_addr) && (wr_addr == rd_addr1);
    fwd2_s = !rst && wr_en && reg_ok(wr_addr) && (wr_addr == rd_addr2);
`else
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
`endif
  end

  // Read-port outputs and the decode stall.
  always_comb begin
    rd_data1 = raw_data1_s;
    rd_data2 = raw_data2_s;
    busy1    = raw_busy1_s;
    busy2    = raw_busy2_s;
    if (fwd1_s) begin
      rd_data1 = wr_data;
      busy1    = issue_en && (issue_addr == rd_addr1);
    end else begin
      rd_data1 = raw_data1_s;
      busy1    = raw_busy1_s;
    end
    if (fwd2_s) begin
      rd_data2 = wr_data;
      busy2    = issue_en && (issue_addr == rd_addr2);
    end else begin
      rd_data2 = raw_data2_s;
      busy2    = raw_busy2_s;
    end
    stall = (use1 && busy1) || (use2 && busy2);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, reset
// corner cases, randomized traffic against a reference model, and a 6x16
// instance for unmapped-address behaviour. Honours RF_BYPASS_EN.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 8x8 instance
  logic [2:0] rd_addr1, rd_addr2, wr_addr, issue_addr;
  logic [7:0] wr_data, rd_data1, rd_data2;
  logic       wr_en, issue_en, use1, use2, busy1, busy2, stall;

  // 6x16 instance
  logic [2:0]  b_rd_addr1, b_rd_addr2, b_wr_addr, b_issue_addr;
  logic [15:0] b_wr_data, b_rd_data1, b_rd_data2;
  logic        b_wr_en, b_issue_en, b_use1, b_use2, b_busy1, b_busy2, b_stall;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy1(busy1), .busy2(busy2), .stall(stall),
    .use1(use1), .use2(use2)
  );

  regfile_scoreboard #(.DATA_W(16), .NUM_REGS(6)) dut6 (
    .clk(clk), .rst(rst),
    .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr),
    .busy1(b_busy1), .busy2(b_busy2), .stall(b_stall),
    .use1(b_use1), .use2(b_use2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (8x8 instance) ----------------
  logic [7:0] mem [8];
  logic       mbusy [8];

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'h00;
      mbusy[i] = 1'b0;
    end
  endfunction

  function automatic logic [7:0] m_data(input logic [2:0] a);
`ifdef RF_BYPASS_EN
    if (wr_en && a != 3'd0 && wr_addr == a) return wr_data;
`endif
    return (a == 3'd0) ? 8'h00 : mem[a];
  endfunction

  function automatic logic m_busy(input logic [2:0] a);
`ifdef RF_BYPASS_EN
    if (wr_en && a != 3'd0 && wr_addr == a) return issue_en && issue_addr == a;
`endif
    return (a == 3'd0) ? 1'b0 : mbusy[a];
  endfunction

  // Apply one clock's worth of architectural effect: clear then set (set wins).
  function automatic void m_commit();
    if (wr_en && wr_addr != 3'd0) mem[wr_addr] = wr_data;
    if (wr_en) mbusy[wr_addr] = 1'b0;
    if (issue_en && issue_addr != 3'd0) mbusy[issue_addr] = 1'b1;
    mbusy[0] = 1'b0;
  endfunction

  task automatic tick();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ie, input logic [2:0] ia,
                       input logic [2:0] a1, input logic [2:0] a2,
                       input logic u1, input logic u2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia;
    rd_addr1 = a1; rd_addr2 = a2; use1 = u1; use2 = u2;
  endtask

  task automatic check_model(input string tag);
    logic e_b1, e_b2;
    e_b1 = m_busy(rd_addr1);
    e_b2 = m_busy(rd_addr2);
    check({tag, " rd_data1"}, 32'(rd_data1), 32'(m_data(rd_addr1)));
    check({tag, " rd_data2"}, 32'(rd_data2), 32'(m_data(rd_addr2)));
    check({tag, " busy1"}, 32'(busy1), 32'(e_b1));
    check({tag, " busy2"}, 32'(busy2), 32'(e_b2));
    check({tag, " stall"}, 32'(stall), 32'((use1 & e_b1) | (use2 & e_b2)));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       ie;
    logic [2:0] ia;
    logic [2:0] a1, a2;
    logic       u1, u2;
    logic [7:0] d1, d2;
    logic       b1, b2, st;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // {we, wa, wd, ie, ia, a1, a2, u1, u2, d1, d2, b1, b2, st}
    vecs[0]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd5, 3'd0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd5, 3'd0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd4, 8'h77, 1'b1, 3'd4, 3'd1, 3'd3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd0, 1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0, 3'd4, 1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 3'd6, 8'h01, 1'b1, 3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
`ifdef RF_BYPASS_EN
    vecs[13] = '{1'b1, 3'd6, 8'h5A, 1'b0, 3'd0, 3'd6, 3'd6, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0};
`else
    vecs[13] = '{1'b1, 3'd6, 8'h5A, 1'b0, 3'd0, 3'd6, 3'd6, 1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1};
`endif
    vecs[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd6, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    b_wr_en = 1'b0; b_wr_addr = 3'd0; b_wr_data = 16'h0000;
    b_issue_en = 1'b0; b_issue_addr = 3'd0;
    b_rd_addr1 = 3'd0; b_rd_addr2 = 3'd0; b_use1 = 1'b0; b_use2 = 1'b0;
    m_reset();
    @(posedge clk);
    #1;

    // Outputs held at zero while reset is high, even with a write pending.
    drive(1'b1, 3'd3, 8'hEE, 1'b1, 3'd5, 3'd3, 3'd5, 1'b1, 1'b1);
    #1;
    check("in-reset rd_data1", 32'(rd_data1), 32'h0);
    check("in-reset rd_data2", 32'(rd_data2), 32'h0);
    check("in-reset busy2", 32'(busy2), 32'h0);
    check("in-reset stall", 32'(stall), 32'h0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Every address reads zero and non-busy after reset.
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'(a), 3'(7 - a), 1'b1, 1'b1);
      #1;
      check($sformatf("post-reset addr%0d", a), {16'h0, rd_data1, rd_data2}, 32'h0);
      check($sformatf("post-reset flags%0d", a), {29'h0, busy1, busy2, stall}, 32'h0);
      tick();
    end

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ia,
            vecs[i].a1, vecs[i].a2, vecs[i].u1, vecs[i].u2);
      #1;
      check($sformatf("vec%0d rd_data1", i), 32'(rd_data1), 32'(vecs[i].d1));
      check($sformatf("vec%0d rd_data2", i), 32'(rd_data2), 32'(vecs[i].d2));
      check($sformatf("vec%0d busy1", i), 32'(busy1), 32'(vecs[i].b1));
      check($sformatf("vec%0d busy2", i), 32'(busy2), 32'(vecs[i].b2));
      check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].st));
      tick();
    end

    // Mid-run asynchronous reset: R3 = A5 and busy, then rst clears without a clock.
    drive(1'b1, 3'd3, 8'hA5, 1'b1, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd2, 1'b1, 1'b0);
    #1;
    check("pre-reset R3", 32'(rd_data1), 32'hA5);
    check("pre-reset busy R3", 32'(busy1), 32'h1);
    check("pre-reset R2", 32'(rd_data2), 32'h11);
    #1;
    rst = 1'b1;
    #1;
    check("async-reset R3", 32'(rd_data1), 32'h0);
    check("async-reset R2", 32'(rd_data2), 32'h0);
    check("async-reset busy R3", 32'(busy1), 32'h0);
    check("async-reset stall", 32'(stall), 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 8'($urandom),
            ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      #1;
      check_model($sformatf("rand%0d", n));
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // 6x16 instance: address 7 (and 6) are unmapped.
    b_wr_en = 1'b1; b_wr_addr = 3'd7; b_wr_data = 16'h1234;
    b_issue_en = 1'b1; b_issue_addr = 3'd7;
    b_rd_addr1 = 3'd7; b_rd_addr2 = 3'd6; b_use1 = 1'b1; b_use2 = 1'b1;
    #1;
    check("n6 same-cycle addr7 data", 32'(b_rd_data1), 32'h0);
    check("n6 same-cycle addr7 busy", 32'(b_busy1), 32'h0);
    check("n6 same-cycle stall", 32'(b_stall), 32'h0);
    @(posedge clk);
    #1;
    b_wr_en = 1'b0; b_issue_en = 1'b0;
    #1;
    check("n6 addr7 data", 32'(b_rd_data1), 32'h0);
    check("n6 addr7 busy", 32'(b_busy1), 32'h0);
    check("n6 addr6 data", 32'(b_rd_data2), 32'h0);
    check("n6 stall", 32'(b_stall), 32'h0);
    b_wr_en = 1'b1; b_wr_addr = 3'd5; b_wr_data = 16'hBEEF;
    b_issue_en = 1'b1; b_issue_addr = 3'd5;
    b_rd_addr1 = 3'd1; b_rd_addr2 = 3'd7;
    @(posedge clk);
    #1;
    b_wr_en = 1'b0; b_issue_en = 1'b0;
    b_rd_addr1 = 3'd5; b_rd_addr2 = 3'd7; b_use1 = 1'b1; b_use2 = 1'b1;
    #1;
    check("n6 R5 data", 32'(b_rd_data1), 32'hBEEF);
    check("n6 R5 busy", 32'(b_busy1), 32'h1);
    check("n6 addr7 still zero", 32'(b_rd_data2), 32'h0);
    check("n6 addr7 still idle", 32'(b_busy2), 32'h0);
    check("n6 R5 stall", 32'(b_stall), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file with a per-register busy scoreboard, for the datapath's decode/writeback stages. It provides two read ports and one write port, and register 0 is hardwired to zero. The scoreboard tracks which registers have an in-flight producer, so decode can detect RAW hazards and raise a stall. It is the drop-in successor to the fixed 8x8 register file, with an explicit write enable, hazard tracking and optional write-through bypass.

Parameters:
DATA_W, 8, width of each register in bits
NUM_REGS, 8, number of registers; must be at least 2
ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
rd_addr1  input  ADDR_W  read port 1 address
rd_addr2  input  ADDR_W  read port 2 address
rd_data1  output  DATA_W  read port 1 data
rd_data2  output  DATA_W  read port 2 data
wr_en  input  1  writeback enable
wr_addr  input  ADDR_W  writeback register address
wr_data  input  DATA_W  writeback data
issue_en  input  1  an instruction with destination issue_addr is issued
issue_addr  input  ADDR_W  destination register being marked busy
busy1  output  1  scoreboard bit for rd_addr1
busy2  output  1  scoreboard bit for rd_addr2
stall  output  1  busy1 | busy2, gated by use flags
use1  input  1  read port 1 operand is actually used
use2  input  1  read port 2 operand is actually used

Behaviour:
- Reset (asynchronous, rst high): all registers cleared to 0 and all busy bits cleared to 0. While rst is high, rd_data1 and rd_data2 = 0, busy1 and busy2 = 0, stall = 0.
- Write: on posedge clk, if wr_en is 1 and wr_addr != 0, reg[wr_addr] <= wr_data. Writes to R0 are ignored.
- Read: combinational. rd_dataN = reg[rd_addrN]. R0 always reads 0.
- Addresses >= NUM_REGS (only possible when NUM_REGS is not a power of two):
  - reads return 0;
  - writes are ignored;
  - issue is ignored;
  - busy reads as 0.
- Scoreboard, per register i (R0 is never busy):
  - set when issue_en && issue_addr == i;
  - cleared when wr_en && wr_addr == i;
  - if set and clear hit the same register in the same cycle, set wins (a new producer supersedes the retiring one). Busy stays 1 and data is still written.
  - Issue to an already-busy register leaves it busy; no counting or nesting.
- busyN = busy[rd_addrN], combinational.
- stall = (use1 & busy1) | (use2 & busy2), combinational.
- Same-cycle write and read of the same address, without the optional feature: the read returns the OLD value, and busy still reads as 1 in that cycle (registered scoreboard). The new value and the cleared busy bit are visible in the next cycle.
- Latency: write-to-read is 1 cycle; issue-to-busy is 1 cycle.
- Reset asserted mid-operation: contents and scoreboard clear immediately, with no clock required. Pending writes in that cycle are lost.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-through bypass. When wr_en && wr_addr == rd_addrN && wr_addr != 0:
  - rd_dataN = wr_data in the same cycle;
  - busyN = 0 in that cycle, unless issue_en && issue_addr == rd_addrN in the same cycle, in which case busyN stays 1;
  - stall follows the bypassed busy values.
- Not defined: behaviour exactly as described in Behaviour (old data, busy still 1 in the write cycle).

Test Plan:
- Reset then read all addresses -> every rd_data = 0, busy1 = busy2 = 0, stall = 0. Assert rst mid-run after writing R3 = 8'hA5 -> R3 reads 0 immediately, before any clock edge.
- Write R5 = 8'h3C, then R0 = 8'hFF; read rd_addr1 = 5, rd_addr2 = 0 next cycle -> rd_data1 = 8'h3C, rd_data2 = 8'h00.
- Issue R2; next cycle rd_addr1 = 2, use1 = 1 -> busy1 = 1, stall = 1. With use1 = 0 -> stall = 0. Writeback R2 = 8'h11 -> next cycle busy1 = 0, rd_data1 = 8'h11.
- Same cycle: issue R4 and writeback R4 = 8'h77 -> next cycle busy[4] = 1 and R4 reads 8'h77. Issue R0 -> busy never asserts for R0.
- Same-cycle write R6 = 8'h5A with rd_addr2 = 6, R6 previously 8'h01 and busy:
  - without RF_BYPASS_EN -> rd_data2 = 8'h01 and busy2 = 1 in that cycle;
  - with RF_BYPASS_EN -> rd_data2 = 8'h5A and busy2 = 0 in that cycle.
- NUM_REGS = 6, DATA_W = 16: write and issue to address 7 -> no effect; read address 7 -> 0 with busy 0; R5 = 16'hBEEF round-trips correctly.
